pc_fetch_ctrl: RTL

//   Consumer end of the pc_src select bus. Holds the architectural PC and

---
 rtl/pc_fetch_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: holds the architectural PC, fetches one instruction at a
// time over a valid/ready request + valid response interface, presents it
// to the single-cycle datapath, and forms the next PC on commit.
// Optional build macro: MISALIGN_TRAP_EN. When defined, a commit to a target
// whose low two bits are non-zero leaves the PC untouched and parks the
// controller in HALT with misalign_err set until reset.
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_inst,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            commit,
  output logic            misalign_err
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2
  } state_t;
`endif

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] jalr_sum;
  logic            pc_load;
  logic            inst_load;
`ifdef MISALIGN_TRAP_EN
  logic            trap_set;
  logic            misalign_q;
`endif

  // Next-PC selection; all sums wrap modulo 2^XLEN
  always_comb begin
    jalr_sum = rs1_val + imm;
    next_pc  = pc_q + XLEN'(32'd4);
    case (pc_src)
      2'b01:   next_pc = pc_q + imm;
      2'b10:   next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      default: next_pc = pc_q + XLEN'(32'd4);
    endcase
  end

  // Fetch FSM next-state and load strobes
  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b0;
    inst_load = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_set  = 1'b0;
`endif
    case (state_q)
      S_REQ: begin
        if (ifu_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ifu_rsp_valid) begin
          inst_load = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (commit) begin
`ifdef MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) begin
            trap_set = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_load = 1'b1;
            state_d = S_REQ;
          end
`else
          pc_load = 1'b1;
          state_d = S_REQ;
`endif
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State, PC and instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pc_load) begin
        pc_q <= next_pc;
      end
      if (inst_load) begin
        inst_q <= ifu_rsp_inst;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (trap_set) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  // Request is held off while reset is asserted so it rises on the first
  // cycle after release rather than being visible during reset.
  assign ifu_req_valid = (state_q == S_REQ) && !rst;
  assign ifu_addr      = pc_q;
  assign inst          = inst_q;
  assign inst_valid    = (state_q == S_EXEC);
  assign pc            = pc_q;
  assign pc_plus4      = pc_q + XLEN'(32'd4);

endmodule
